im_fetch_ctrl: RTL and testbench
================================

# im_fetch_ctrl

Instruction-fetch controller between the IF-stage PC logic and the synchronous-read instruction block RAM. It hides the RAM's one-cycle read latency so the core runs on a single clock. Each fetch is a valid/ready request and response, so a stalled decode stage never loses an instruction. Misaligned and out-of-range fetch addresses are flagged as AdEL and answered with a NOP without touching the RAM.

## Interface
Parameters:
- IM_BASE, 32'h0000_0000, byte address of the first instruction word
- IM_BYTES, 8192, size of the instruction region in bytes
- ADDR_W, 11, RAM word-address width (log2(IM_BYTES/4))

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  PC logic offers a fetch
- req_pc  in  32  byte address to fetch
- req_ready  out  1  controller accepts the request this cycle
- rsp_valid  out  1  response available
- rsp_instr  out  32  fetched instruction; 32'h0 on an address error
- rsp_pc  out  32  PC of the response
- rsp_adel  out  1  fetch address error (PC[1:0]≠0 or PC outside the region)
- rsp_ready  in  1  IF/ID accepts the response (low means stall)
- flush  in  1  squash all pending responses (branch or exception redirect)
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM word address
- ram_dout  in  32  RAM read data, valid one cycle after ram_en

## Operation
- Address check is combinational on req_pc.
  - In range: IM_BASE ≤ req_pc ≤ IM_BASE+IM_BYTES-1 and req_pc[1:0]==0.
  - ram_addr = (req_pc−IM_BASE)[ADDR_W+1:2].
- Accept: a request is accepted when req_valid & req_ready. ram_en = accept & in-range.
- Every accepted request also registers meta = {pc, adel}.
  - An out-of-range request still occupies the read slot with adel=1.
  - Its response is rsp_instr=32'h0 and rsp_adel=1.
- FSM states:
  - IDLE: no response pending.
  - RD: read issued last cycle; the response is taken from ram_dout.
  - HELD: the response sits in the hold register.
- req_ready = (state==IDLE) | rsp_ready | flush.
- rsp_valid = (state≠IDLE) & ~flush.
- Response source: in RD, instr comes from ram_dout (or 0 if adel), meta from the registered meta. In HELD, instr and meta come from the hold register.
- Transitions:
  - IDLE: accept → RD; otherwise stay in IDLE.
  - RD & rsp_ready: accept → RD; otherwise → IDLE.
  - RD & ~rsp_ready: → HELD. The RD response is captured into the hold register. No accept is possible (req_ready=0).
  - HELD & rsp_ready: accept → RD; otherwise → IDLE.
  - HELD & ~rsp_ready: stay in HELD. Hold contents are stable.
- Flush overrides everything:
  - The current response is dropped.
  - Next state is RD if a request is accepted in the same cycle (the redirect target), else IDLE.
- A response is never duplicated or reordered. rsp_pc sequence equals the accepted req_pc sequence minus flushed entries.

## Timing
- Latency: response is valid exactly 1 cycle after acceptance when there is no stall.
- Throughput: one fetch per cycle with rsp_ready held high; there are no bubbles after a stall releases.
- rsp_* stay stable while rsp_valid & ~rsp_ready.
- Reset values, applied asynchronously: state=IDLE, hold register=0, meta=0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_adel=0, ram_en=0, req_ready=1.
- Reset asserted mid-RD or mid-HELD discards the response with no further handshake.
- req_ready depends combinationally on rsp_ready and flush. There is no combinational path from req_valid to req_ready.
- ram_en is never asserted for an address-error request.

## Structure
- Shared package/header im_pkg:
  - IM_BASE, IM_BYTES and NOP_INSTR (32'h0).
  - The state encoding (IDLE=2'd0, RD=2'd1, HELD=2'd2).
  - The response record layout {instr, pc, adel}.
- One natural sub-module: im_addr_check, the combinational range/alignment check plus word-address generation. The decode and exception stages reuse it for data-side AdEL.

## Test plan
- Reset, then fetch 0x0, 0x4, 0x8 back-to-back with rsp_ready=1 and RAM preloaded with 0x3C01_0001, 0x3421_0002, 0x0000_0000. Required: responses in cycles 1, 2, 3 with matching rsp_pc, ram_en high for 3 cycles, req_ready=1 throughout.
- Fetch 0x10, then hold rsp_ready=0 for 3 cycles. Required: state RD→HELD, rsp_instr and rsp_pc stable, req_ready=0, ram_en=0. Release with req 0x14 → 0x10 is consumed, then 0x14 responds the next cycle.
- Fetch 0x2 and 0x2000. Required: ram_en=0, rsp_adel=1, rsp_instr=0. Fetch 0x1FFC → adel=0 with normal data.
- In HELD, assert flush with req_pc=0x100. Required: no response that cycle, and the next cycle rsp_pc=0x100. Flush with no request → IDLE, rsp_valid=0.
- Assert reset asynchronously mid-RD, between clock edges. Required: rsp_valid, ram_en and rsp_instr go to 0 before the next edge. After release the first fetch behaves as in scenario 1.

Source files
------------

// File: rtl/im_pkg.sv
// im_pkg: shared definitions for the instruction-fetch path.
//   IM_BASE / IM_BYTES : default instruction region (byte address, size)
//   NOP_INSTR          : instruction returned for an address-error fetch
//   im_state_e         : fetch controller FSM encoding
//   im_rsp_t           : response record {instr, pc, adel}
package im_pkg;

  localparam logic [31:0] IM_BASE   = 32'h0000_0000;
  localparam logic [31:0] IM_BYTES  = 32'd8192;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no response pending
    ST_RD   = 2'd1,  // read issued last cycle, data on the RAM output
    ST_HELD = 2'd2   // stalled response parked in the hold register
  } im_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } im_rsp_t;

endpackage

// File: rtl/im_addr_check.sv
// im_addr_check: combinational range/alignment check for a byte address
// against a region [BASE, BASE+BYTES-1], plus the region-relative word
// address. Shared by instruction fetch and the data-side AdEL logic.
//   addr_i      : byte address under test
//   adel_o      : 1 when misaligned (addr[1:0]!=0) or outside the region
//   word_addr_o : (addr - BASE) >> 2, truncated to ADDR_W bits
module im_addr_check #(
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter logic [31:0] BYTES  = 32'd8192,
  parameter int unsigned ADDR_W = 11
) (
  input  logic [31:0]       addr_i,
  output logic              adel_o,
  output logic [ADDR_W-1:0] word_addr_o
);

  logic [31:0] offset;
  logic        in_range;

  // Region-relative offset; the >= BASE term rejects wrapped offsets below the base.
  always_comb begin
    offset      = addr_i - BASE;
    in_range    = (addr_i >= BASE) && (offset < BYTES);
    adel_o      = ~in_range | (addr_i[1:0] != 2'b00);
    word_addr_o = offset[ADDR_W+1:2];
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: valid/ready fetch controller in front of a synchronous-read
// instruction RAM (one-cycle read latency). Misaligned or out-of-region
// fetches are answered with NOP_INSTR and adel=1 without enabling the RAM.
//   clk_i, reset_i            : clock, async active-high reset
//   req_valid_i/req_pc_i      : fetch request from PC logic
//   req_ready_o               : request accepted this cycle
//   rsp_valid_o/rsp_instr_o/rsp_pc_o/rsp_adel_o : fetch response
//   rsp_ready_i               : downstream accepts the response
//   flush_i                   : drop the pending response (redirect)
//   ram_en_o/ram_addr_o/ram_dout_i : instruction RAM port
module im_fetch_ctrl #(
  parameter logic [31:0] IM_BASE  = im_pkg::IM_BASE,
  parameter logic [31:0] IM_BYTES = im_pkg::IM_BYTES,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  input  logic [31:0]       req_pc_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_instr_o,
  output logic [31:0]       rsp_pc_o,
  output logic              rsp_adel_o,
  input  logic              rsp_ready_i,
  input  logic              flush_i,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [31:0]       ram_dout_i
);

  import im_pkg::*;

  im_state_e   state_q, state_d;
  im_rsp_t     hold_q, hold_d;
  im_rsp_t     rsp_cur;
  logic [31:0] meta_pc_q, meta_pc_d;
  logic        meta_adel_q, meta_adel_d;
  logic        req_adel;
  logic [ADDR_W-1:0] req_word_addr;
  logic        accept;

  im_addr_check #(
    .BASE   (IM_BASE),
    .BYTES  (IM_BYTES),
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .addr_i      (req_pc_i),
    .adel_o      (req_adel),
    .word_addr_o (req_word_addr)
  );

  // Handshake, RAM control, response mux and next-state logic.
  always_comb begin
    // req_ready never looks at req_valid, so there is no valid->ready loop.
    req_ready_o = (state_q == ST_IDLE) | rsp_ready_i | flush_i;
    accept      = req_valid_i & req_ready_o;
    // Gated by reset so the RAM stays idle while reset is asserted.
    ram_en_o    = accept & ~req_adel & ~reset_i;
    ram_addr_o  = req_word_addr;

    case (state_q)
      ST_RD: begin
        rsp_cur.instr = meta_adel_q ? NOP_INSTR : ram_dout_i;
        rsp_cur.pc    = meta_pc_q;
        rsp_cur.adel  = meta_adel_q;
      end
      ST_HELD: rsp_cur = hold_q;
      default: rsp_cur = '0;
    endcase

    rsp_valid_o = (state_q != ST_IDLE) & ~flush_i;
    rsp_instr_o = rsp_cur.instr;
    rsp_pc_o    = rsp_cur.pc;
    rsp_adel_o  = rsp_cur.adel;

    state_d     = state_q;
    hold_d      = hold_q;
    meta_pc_d   = meta_pc_q;
    meta_adel_d = meta_adel_q;

    if (accept) begin
      meta_pc_d   = req_pc_i;
      meta_adel_d = req_adel;
    end else begin
      meta_pc_d   = meta_pc_q;
      meta_adel_d = meta_adel_q;
    end

    if (flush_i) begin
      // Redirect: drop whatever is pending; a same-cycle request is the target.
      state_d = accept ? ST_RD : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = accept ? ST_RD : ST_IDLE;
        ST_RD: begin
          if (rsp_ready_i) begin
            state_d = accept ? ST_RD : ST_IDLE;
          end else begin
            // RAM output is only valid this cycle, so park it.
            state_d = ST_HELD;
            hold_d  = rsp_cur;
          end
        end
        ST_HELD: state_d = rsp_ready_i ? (accept ? ST_RD : ST_IDLE) : ST_HELD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, hold and meta registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      meta_pc_q   <= 32'h0000_0000;
      meta_adel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      meta_pc_q   <= meta_pc_d;
      meta_adel_q <= meta_adel_d;
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Testbench for im_fetch_ctrl: behavioural synchronous RAM, scoreboard of
// expected responses pushed on acceptance and popped on consumption.
module tb_im_fetch_ctrl;
  import im_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req_valid, rsp_ready, flush;
  logic [31:0] req_pc;
  logic        req_ready, rsp_valid, rsp_adel, ram_en;
  logic [31:0] rsp_instr, rsp_pc, ram_dout;
  logic [10:0] ram_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:2047];
  im_rsp_t     sb[$];

  im_fetch_ctrl dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_pc_i(req_pc), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_instr_o(rsp_instr), .rsp_pc_o(rsp_pc),
    .rsp_adel_o(rsp_adel), .rsp_ready_i(rsp_ready), .flush_i(flush),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  function automatic logic model_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'h0000_2000);
  endfunction

  // One clock of scoreboard checking: sample at negedge, advance to posedge+1.
  task automatic sb_cycle();
    logic    exp_ready, exp_valid, acc, adel;
    im_rsp_t e, got;
    @(negedge clk);
    exp_ready = (sb.size() == 0) || rsp_ready || flush;
    exp_valid = (sb.size() != 0) && !flush;
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++; $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
    end
    vectors++;
    if (rsp_valid !== exp_valid) begin
      miscompares++; $display("FAIL rsp_valid @%0t: got %b expected %b", $time, rsp_valid, exp_valid);
    end
    if (exp_valid) begin
      e = sb[0];
      got = '{instr: rsp_instr, pc: rsp_pc, adel: rsp_adel};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL rsp_data @%0t: got instr=%h pc=%h adel=%b expected instr=%h pc=%h adel=%b",
                 $time, rsp_instr, rsp_pc, rsp_adel, e.instr, e.pc, e.adel);
      end
      if (rsp_ready) void'(sb.pop_front());
    end
    if (flush) sb.delete();
    acc  = req_valid && exp_ready;
    adel = model_adel(req_pc);
    vectors++;
    if (ram_en !== (acc && !adel)) begin
      miscompares++; $display("FAIL ram_en @%0t: got %b expected %b", $time, ram_en, acc && !adel);
    end
    if (acc) begin
      if (!adel) begin
        vectors++;
        if (ram_addr !== req_pc[12:2]) begin
          miscompares++; $display("FAIL ram_addr @%0t: got %h expected %h", $time, ram_addr, req_pc[12:2]);
        end
      end
      sb.push_back('{instr: adel ? 32'h0 : mem[req_pc[12:2]], pc: req_pc, adel: adel});
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rr, input logic fl);
    req_valid = v; req_pc = pc; rsp_ready = rr; flush = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(1'b0, 32'h0, 1'b1, 1'b0);
    #12;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (rsp_instr !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_instr: got %h expected 0", rsp_instr); end
    vectors++; if (rsp_pc !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_pc: got %h expected 0", rsp_pc); end
    vectors++; if (rsp_adel !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_adel: got %b expected 0", rsp_adel); end
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      sb_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    sb_cycle();
    sb_cycle();
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    sb_cycle();
    // Keep offering 0x14 while stalled; it must not be taken.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h14, 1'b0, 1'b0);
      sb_cycle();
      vectors++;
      if (dut.state_q !== ST_HELD) begin
        miscompares++; $display("FAIL stall_state: got %0d expected %0d", dut.state_q, ST_HELD);
      end
    end
    drive(1'b1, 32'h14, 1'b1, 1'b0);
    sb_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    sb_cycle();
    sb_cycle();
  endtask

  task automatic test_adel();
    drive(1'b1, 32'h2, 1'b1, 1'b0);    sb_cycle();
    drive(1'b1, 32'h2000, 1'b1, 1'b0); sb_cycle();
    drive(1'b1, 32'h1FFC, 1'b1, 1'b0); sb_cycle();
    drive(1'b1, 32'h1FFF, 1'b1, 1'b0); sb_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);    sb_cycle();
    sb_cycle();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 1'b1, 1'b0); sb_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);  sb_cycle();
    sb_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1); sb_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);   sb_cycle();
    drive(1'b1, 32'h30, 1'b1, 1'b0);  sb_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1);   sb_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0);   sb_cycle();
    sb_cycle();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    sb_cycle();
    drive(1'b1, 32'h44, 1'b1, 1'b0);
    #1;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_rsp_valid: got %b expected 1", rsp_valid); end
    reset = 1'b1;
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL areset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL areset_ram_en: got %b expected 0", ram_en); end
    vectors++; if (rsp_instr !== 32'h0) begin miscompares++; $display("FAIL areset_rsp_instr: got %h expected 0", rsp_instr); end
    vectors++; if (rsp_pc !== 32'h0) begin miscompares++; $display("FAIL areset_rsp_pc: got %h expected 0", rsp_pc); end
    sb.delete();
    #1;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    sb_cycle();
    test_back_to_back();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0]     = 32'h3C01_0001;
    mem[1]     = 32'h3421_0002;
    mem[2]     = 32'h0000_0000;
    mem[11'h7FF] = 32'hDEAD_BEEF;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    test_reset();
    test_back_to_back();
    test_stall();
    test_adel();
    test_flush();
    test_async_reset();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
